// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
//   state_e    : detector state (IDLE / ARMED)
//   len_width  : width needed to hold a pattern length 0..pat_w
//   len_mask   : low-bit mask with 'len' ones, used to compare the active bits
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int unsigned MASK_MAX_W = 64;

  function automatic int unsigned len_width(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic logic [MASK_MAX_W-1:0] len_mask(input int unsigned len);
    if (len >= MASK_MAX_W) begin
      return '1;
    end
    return (64'd1 << len) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with clear priority.
//   clk, rst : clock, async active-low reset
//   i_clr    : clear; with i_inc in the same cycle the count restarts at 1
//   i_inc    : increment, holds at all-ones
//   o_cnt    : registered count
module seq_det_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? CNT_W'(1) : '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlap control and a
// saturating match counter.
//   clk, rst         : clock, async active-low reset
//   cfg_load         : latch cfg_pattern/cfg_len/cfg_overlap and arm
//   cfg_pattern      : pattern, bit [cfg_len-1] arrives first, bit [0] last
//   cfg_len          : active length 1..PAT_W
//   cfg_overlap      : 1 = overlapping, 0 = non-overlapping detection
//   din_valid, din   : serial input bit and its qualifier
//   cnt_clr          : clear the match counter
//   armed            : detector configured and running
//   match            : one-cycle pulse, one cycle after the completing bit
//   match_cnt        : saturating match count
//   cfg_err          : one-cycle pulse on a rejected cfg_load
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             din_valid,
  input  logic             din,
  input  logic             cnt_clr,
  output logic             armed,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  state_e           r_state;
  logic [PAT_W-1:0] r_hist;
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_fill;
  logic             r_ovl;
  logic             r_armed;
  logic             r_match;
  logic             r_cfg_err;

  logic             w_cfg_ok;
  logic             w_load_ok;
  logic             w_sample;
  logic [PAT_W-1:0] w_hist_nxt;
  logic [LEN_W-1:0] w_fill_nxt;
  logic [PAT_W-1:0] w_mask;
  logic             w_hit;

  assign w_cfg_ok   = (cfg_len != '0) && (32'(cfg_len) <= 32'(PAT_W));
  assign w_load_ok  = cfg_load && w_cfg_ok;
  // Any cfg_load cycle discards din, whether or not the load is accepted.
  assign w_sample   = (r_state == ARMED) && din_valid && !cfg_load;
  assign w_hist_nxt = {r_hist[PAT_W-2:0], din};
  assign w_fill_nxt = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
  assign w_mask     = PAT_W'(len_mask(32'(r_len)));
  // fill tracks how many fresh bits are in hist; a hit needs a full window.
  assign w_hit      = w_sample && (w_fill_nxt == r_len) &&
                      (((w_hist_nxt ^ r_pat) & w_mask) == '0);

  // State, config, history and registered pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_hist    <= '0;
      r_pat     <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_ovl     <= 1'b0;
      r_armed   <= 1'b0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_hit;
      r_cfg_err <= cfg_load && !w_cfg_ok;

      case (r_state)
        IDLE: begin
          if (w_load_ok) begin
            r_state <= ARMED;
            r_armed <= 1'b1;
          end
        end
        ARMED: begin
          r_state <= ARMED;
        end
        default: begin
          r_state <= IDLE;
          r_armed <= 1'b0;
        end
      endcase

      if (w_load_ok) begin
        r_pat  <= cfg_pattern;
        r_len  <= cfg_len;
        r_ovl  <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_sample) begin
        r_hist <= w_hist_nxt;
        // Non-overlap restarts the window after a hit.
        r_fill <= (w_hit && !r_ovl) ? '0 : w_fill_nxt;
      end
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (cnt_clr),
    .i_inc (w_hit),
    .o_cnt (match_cnt)
  );

  assign armed   = r_armed;
  assign match   = r_match;
  assign cfg_err = r_cfg_err;

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, run-time programmable serial pattern detector; successor to the fixed 3-bit "101" Moore detector.
- Samples one bit per qualified cycle.
- Compares the last cfg_len bits against a programmed pattern and emits a registered one-cycle match pulse.
- Supports overlapping and non-overlapping detection.
- Keeps a saturating match counter.
- Sits on serial bit streams in front of framing/sync logic.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of the saturating match counter
LEN_W, $clog2(PAT_W+1), width of cfg_len (derived, not overridden)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous active-low reset
cfg_load  input  1  latch cfg_pattern/cfg_len/cfg_overlap and arm the detector
cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first bit received, bit [0] the last
cfg_len  input  LEN_W  active pattern length, valid range 1..PAT_W
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
din_valid  input  1  din is sampled this cycle
din  input  1  serial data bit
cnt_clr  input  1  clear match counter
armed  output  1  detector configured and running
match  output  1  one-cycle pulse, pattern detected
match_cnt  output  CNT_W  number of matches, saturating
cfg_err  output  1  one-cycle pulse, cfg_load rejected

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; all outputs 0; hist, fill, latched config and match_cnt all 0.
- State machine: two states, IDLE and ARMED.
  - IDLE: din ignored; match never asserts.
  - IDLE -> ARMED on a valid cfg_load.
  - ARMED -> ARMED on a valid cfg_load (reconfigure).
  - No other exit except reset.
- Valid cfg_load means 1 <= cfg_len <= PAT_W. On a valid cfg_load:
  - latch config; clear hist and fill;
  - din in that same cycle is discarded;
  - armed=1 from the next cycle.
- Invalid cfg_load (cfg_len=0 or >PAT_W):
  - ignored; state and config unchanged;
  - cfg_err=1 for one cycle.
- ARMED, din_valid=1, no cfg_load:
  - hist <= {hist[PAT_W-2:0], din};
  - fill <= min(fill+1, len).
  - Hit: the new fill equals len AND the low len bits of the new hist equal the low len bits of pattern.
- On a hit:
  - match=1 in the cycle after the sampling edge (registered Moore output, 1-cycle latency), for exactly one cycle.
  - match_cnt increments on the same edge.
- After a hit:
  - Overlap mode: fill stays at len, so the next bit may complete another match.
  - Non-overlap mode: fill <= 0; a full len fresh bits are required before the next match.
- din_valid=0: hist and fill hold; match=0.
- match_cnt:
  - saturates at 2^CNT_W-1 and never wraps;
  - cnt_clr has priority; cnt_clr and a hit in the same cycle gives match_cnt=1;
  - cnt_clr alone gives 0;
  - cfg_load does not clear it.
- len=1: every valid bit equal to pattern[0] matches; in non-overlap mode, consecutive matching bits still each match.
- Reset mid-stream: everything returns to IDLE immediately; any partial history is lost; reconfiguration is required.

Decomposition:
- Package seq_det_pkg:
  - state enum {IDLE, ARMED};
  - LEN_W helper function;
  - mask-generation function (len -> PAT_W-bit low mask).
- One sub-module, seq_det_sat_cnt: CNT_W saturating counter with clr/inc inputs and clr priority. Reused by later blocks.

Test Plan:
- Config 3'b101, len=3, overlap=1; stream 1,0,1,0,1 (valid every cycle) -> match pulses one cycle after the 3rd and 5th bits; match_cnt=2.
- Same stream with overlap=0 -> single match after the 3rd bit; match_cnt=1; a 6th-8th bit sequence 1,0,1 then gives a second match.
- len=8, pattern 8'hA5, bits streamed with din_valid toggling 1/0 -> exactly one match, one cycle after the final valid 1; idle cycles do not break detection.
- cfg_load with cfg_len=0, then with cfg_len=9 -> cfg_err pulses each time; armed stays 0; no match on any stream.
- CNT_W=2, overlap=1, len=1, pattern 1, six consecutive 1s -> match_cnt goes 1,2,3,3,3,3. Then cnt_clr together with a hit -> match_cnt=1.
- Assert rst low after 2 of 3 pattern bits, release, re-load config, send the final bit only -> no match; armed=0 until the reload.
